// File: rtl/serial_deser_32_pkg.sv
// Shared constants and types for the serial deserialiser and its output buffer.
package serial_deser_32_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_e;

    // Bit-order select, common with the shift-register mode/dir encoding
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_deser_32_deser_out_buf.sv
// One-word holding register with valid/ack handshake and sticky overrun flag.
module deser_out_buf
    import serial_deser_32_pkg::*;
#(
    parameter int unsigned WIDTH = serial_deser_32_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             complete_i,
    input  logic [WIDTH-1:0] cand_i,
    input  logic             ack,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             overrun
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ovr_set;

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ovr_set = 1'b0;
        if (complete_i) begin
            if (!valid_q || ack) begin
                q_d     = cand_i;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end
        // A fresh overrun beats a simultaneous clear
        ovr_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign q       = q_q;
    assign valid   = valid_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/serial_deser_32.sv
// Serial-to-parallel receiver: frames words on sync, assembles LSB- or MSB-first.
module serial_deser_32
    import serial_deser_32_pkg::*;
#(
    parameter int unsigned WIDTH = serial_deser_32_pkg::WIDTH,
    parameter int unsigned CNT_W = serial_deser_32_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             sync,
    input  logic             dir,
    input  logic             s_in,
    input  logic             ack,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    assign shifted = (dir_q == DIR_MSB_FIRST) ? {sh_q[WIDTH-2:0], s_in}
                                              : {s_in, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        dir_d    = dir_q;
        complete = 1'b0;
        if (enb) begin
            if (sync) begin
                // First bit lands where WIDTH-1 further shifts carry it to its final slot
                state_d = ST_RECV;
                cnt_d   = CNT_W'(1);
                dir_d   = dir;
                sh_d    = (dir == DIR_MSB_FIRST) ? {{(WIDTH-1){1'b0}}, s_in}
                                                 : {s_in, {(WIDTH-1){1'b0}}};
            end else if (state_q == ST_RECV) begin
                sh_d = shifted;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dir_q   <= DIR_LSB_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dir_q   <= dir_d;
        end
    end

    assign busy = (state_q == ST_RECV);

    deser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .complete_i (complete),
        .cand_i     (shifted),
        .ack        (ack),
        .clr_ovr    (clr_ovr),
        .q          (q),
        .valid      (valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_deser_32.sv
// Directed bench for serial_deser_32: word table plus hand-built corner sequences.
module tb_serial_deser_32;

    logic        clk = 1'b0;
    logic        reset, enb, sync, dir, s_in, ack, clr_ovr;
    logic [31:0] q;
    logic        valid, busy, overrun;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic valid_prev = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        d;
        logic        gaps;
        logic        pre_ack;
        logic [31:0] exp_q;
        logic        exp_valid;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[4];

    serial_deser_32 #(.WIDTH(32), .CNT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .sync    (sync),
        .dir     (dir),
        .s_in    (s_in),
        .ack     (ack),
        .clr_ovr (clr_ovr),
        .q       (q),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid && !valid_prev) rises++;
        valid_prev = valid;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Sends nbits of a word; sync on the first bit. Gap cycles drive junk sync/dir with enb=0.
    task automatic send_word(input logic [31:0] data, input logic d, input logic gaps,
                             input logic ack_last, input logic clr_last, input int nbits,
                             input logic mid_chk);
        for (int i = 0; i < nbits; i++) begin
            enb     = 1'b1;
            sync    = (i == 0);
            dir     = d;
            s_in    = d ? data[31-i] : data[i];
            ack     = ack_last && (i == 31);
            clr_ovr = clr_last && (i == 31);
            tick();
            enb = 1'b0; sync = 1'b0; ack = 1'b0; clr_ovr = 1'b0;
            if (mid_chk && i == 30) begin
                chk("busy_before_last", 32'(busy), 32'd1);
                chk("no_early_valid", 32'(valid), 32'd0);
            end
            if (gaps && i != nbits - 1) begin
                sync = 1'b1;
                dir  = ~d;
                s_in = ~s_in;
                tick();
                sync = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enb = 1'b0; sync = 1'b0; dir = 1'b0; s_in = 1'b0;
        ack = 1'b0; clr_ovr = 1'b0;

        vecs[0] = '{data:32'hA5A5F00F, d:1'b0, gaps:1'b0, pre_ack:1'b0,
                    exp_q:32'hA5A5F00F, exp_valid:1'b1, exp_ovr:1'b0};
        vecs[1] = '{data:32'h12345678, d:1'b1, gaps:1'b1, pre_ack:1'b1,
                    exp_q:32'h12345678, exp_valid:1'b1, exp_ovr:1'b0};
        vecs[2] = '{data:32'h3C3CA5A5, d:1'b0, gaps:1'b1, pre_ack:1'b1,
                    exp_q:32'h3C3CA5A5, exp_valid:1'b1, exp_ovr:1'b0};
        vecs[3] = '{data:32'h80000001, d:1'b1, gaps:1'b0, pre_ack:1'b1,
                    exp_q:32'h80000001, exp_valid:1'b1, exp_ovr:1'b0};

        tick(); tick();
        reset = 1'b0;
        chk("rst_q", q, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);

        // enb without sync in IDLE must not start a word
        enb = 1'b1; s_in = 1'b1;
        tick();
        enb = 1'b0;
        chk("idle_no_sync_busy", 32'(busy), 32'd0);

        foreach (vecs[k]) begin
            if (vecs[k].pre_ack) begin
                idle_ack();
                chk($sformatf("v%0d_acked", k), 32'(valid), 32'd0);
            end
            send_word(vecs[k].data, vecs[k].d, vecs[k].gaps, 1'b0, 1'b0, 32, 1'b1);
            chk($sformatf("v%0d_q", k), q, vecs[k].exp_q);
            chk($sformatf("v%0d_valid", k), 32'(valid), 32'(vecs[k].exp_valid));
            chk($sformatf("v%0d_ovr", k), 32'(overrun), 32'(vecs[k].exp_ovr));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
        end

        // Overrun: two back-to-back words without ack
        idle_ack();
        send_word(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0);
        send_word(32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0);
        chk("ovr_q_held", q, 32'hDEADBEEF);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(valid), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_clr_q", q, 32'hDEADBEEF);

        // ack coinciding with completion replaces the word, no overrun
        send_word(32'hCAFEBABE, 1'b0, 1'b0, 1'b1, 1'b0, 32, 1'b0);
        chk("ackcomp_q", q, 32'hCAFEBABE);
        chk("ackcomp_valid", 32'(valid), 32'd1);
        chk("ackcomp_ovr", 32'(overrun), 32'd0);

        // New overrun wins over simultaneous clr_ovr
        send_word(32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1, 32, 1'b0);
        chk("setwins_ovr", 32'(overrun), 32'd1);
        chk("setwins_q", q, 32'hCAFEBABE);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("setwins_clr", 32'(overrun), 32'd0);

        // Resync at bit 10 abandons the partial word
        idle_ack();
        rises = 0;
        send_word(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b0);
        send_word(32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b1);
        tick();
        chk("resync_q", q, 32'h0F0F0F0F);
        chk("resync_rises", 32'(rises), 32'd1);
        chk("resync_ovr", 32'(overrun), 32'd0);

        // Reset mid-word discards the partial word
        idle_ack();
        send_word(32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b0);
        chk("midrst_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rises = 0;
        chk("midrst_q", q, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        send_word(32'h00FF00FF, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b1);
        tick();
        chk("midrst_newq", q, 32'h00FF00FF);
        chk("midrst_rises", 32'(rises), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
